spi_master_gen: RTL

Parametrised, full-duplex SPI master. It is the next-generation replacement for the fixed 32-bit read/write SPI engine on the ADC/DAC serial path. It adds generated SCLK with a programmable divider, a chip-select with setup and hold guards, all four CPOL/CPHA modes, a per-transfer bit length, MSB- or LSB-first ordering, and a start/busy/done handshake. It sits between the converter control FSMs and the ADC/DAC pins.

---
 rtl/spi_master_gen_if.sv | 25 ++
 rtl/spi_master_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/spi_master_gen_if.sv
// Control-side handshake between a converter control FSM and the SPI master.
// The requester uses the master modport; the SPI engine uses the slave modport.
interface spi_master_gen_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 7
);
  logic              start;
  logic [1:0]        mode;
  logic              lsb_first;
  logic [LEN_W-1:0]  xfer_len;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, lsb_first, xfer_len, tx_data,
    input  rx_data, busy, done
  );

  modport slave (
    input  start, mode, lsb_first, xfer_len, tx_data,
    output rx_data, busy, done
  );
endinterface

// File: rtl/spi_master_gen.sv
// Full-duplex SPI master: programmable SCLK divider, CS setup/hold guards,
// all four CPOL/CPHA modes, per-frame length and MSB/LSB-first ordering.
module spi_master_gen #(
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 7,
  parameter int DIV      = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic            clk,
  input  logic            rst,
  spi_master_gen_if.slave ctrl,
  output logic            sclk,
  output logic            cs_n,
  output logic            mosi,
  input  logic            miso
);

  localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int DV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EG_W   = LEN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD
  } state_t;

  state_t state, state_nxt;

  logic              cpol_q, cpha_q, lsb_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] tx_sh, rx_sh, rx_q;
  logic              sclk_q, cs_n_q, mosi_q, busy_q, done_q;
  logic [PH_W-1:0]   ph_cnt;
  logic [DV_W-1:0]   div_cnt;
  logic [EG_W-1:0]   edge_cnt;

  logic [LEN_W-1:0]  eff_len, pad_len, pad_q;
  logic [DATA_W-1:0] tx_align;
  logic              accept, setup_end, tick, leading, last_edge;
  logic              sample, advance, hold_end;

  // Out-of-range lengths fall back to a full-width frame.
  always_comb begin
    eff_len  = (ctrl.xfer_len == '0 || ctrl.xfer_len > LEN_W'(DATA_W))
             ? LEN_W'(DATA_W) : ctrl.xfer_len;
    pad_len  = LEN_W'(DATA_W) - eff_len;
    pad_q    = LEN_W'(DATA_W) - len_q;
    // MSB-first frames are left-justified so the next bit is always the top bit.
    tx_align = ctrl.lsb_first ? ctrl.tx_data : (ctrl.tx_data << pad_len);
  end

  always_comb begin
    accept    = (state == ST_IDLE) && ctrl.start;
    setup_end = (state == ST_SETUP) && (ph_cnt == PH_W'(CS_SETUP - 1));
    tick      = (state == ST_XFER) && (div_cnt == DV_W'(DIV - 1));
    leading   = ~edge_cnt[0];
    last_edge = (edge_cnt == ({len_q, 1'b0} - EG_W'(1)));
    sample    = tick && (cpha_q ? ~leading : leading);
    // Both phases present L-1 new bits; CPHA=1 re-drives the first bit on edge 1.
    advance   = tick && (cpha_q ? (leading && (edge_cnt != '0))
                                : (~leading && ~last_edge));
    hold_end  = (state == ST_HOLD) && (ph_cnt == PH_W'(CS_HOLD - 1));
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (ctrl.start)       state_nxt = ST_SETUP;
      ST_SETUP: if (setup_end)        state_nxt = ST_XFER;
      ST_XFER:  if (tick && last_edge) state_nxt = ST_HOLD;
      ST_HOLD:  if (hold_end)         state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      len_q    <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ph_cnt   <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      done_q <= 1'b0;

      if (state != state_nxt)                        ph_cnt <= '0;
      else if (state == ST_SETUP || state == ST_HOLD) ph_cnt <= ph_cnt + PH_W'(1);

      if (state == ST_XFER) div_cnt <= (div_cnt == DV_W'(DIV - 1)) ? '0 : div_cnt + DV_W'(1);
      else                  div_cnt <= '0;

      if (accept)    edge_cnt <= '0;
      else if (tick) edge_cnt <= edge_cnt + EG_W'(1);

      if (accept) begin
        cpol_q <= ctrl.mode[1];
        cpha_q <= ctrl.mode[0];
        lsb_q  <= ctrl.lsb_first;
        len_q  <= eff_len;
        tx_sh  <= tx_align;
        mosi_q <= ctrl.lsb_first ? tx_align[0] : tx_align[DATA_W-1];
        rx_sh  <= '0;
        sclk_q <= ctrl.mode[1];
        cs_n_q <= 1'b0;
        busy_q <= 1'b1;
      end

      if (tick) sclk_q <= ~sclk_q;

      if (sample)
        rx_sh <= lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};

      if (advance) begin
        tx_sh  <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
        mosi_q <= lsb_q ? tx_sh[1] : tx_sh[DATA_W-2];
      end

      if (hold_end) begin
        cs_n_q <= 1'b1;
        busy_q <= 1'b0;
        done_q <= 1'b1;
        mosi_q <= 1'b0;
        // LSB-first bits were shifted in from the top; bring them down to bit 0.
        rx_q   <= lsb_q ? (rx_sh >> pad_q) : rx_sh;
      end
    end
  end

  assign sclk         = sclk_q;
  assign cs_n         = cs_n_q;
  assign mosi         = mosi_q;
  assign ctrl.busy    = busy_q;
  assign ctrl.done    = done_q;
  assign ctrl.rx_data = rx_q;

endmodule
